// File: rtl/output64_tx.sv
// UART transmitter for 64-bit words with 0xAA preamble / 0x55 postamble session framing.
// Words go out MSB byte first; each byte is start, LSB-first data, then stop bit(s).
//
// state  | meaning
// IDLE   | no session, line high, waiting for open_req
// OPEN   | sending 8x 0xAA preamble
// ACTIVE | session open, word_ready high
// SEND   | sending the captured word, MSB byte first
// CLOSE  | sending 8x 0x55 postamble, then back to IDLE
module output64_tx #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int CLKS_PER_BIT = CLK_HZ / BIT_RATE,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        open_req,
    input  logic        close_req,
    input  logic        word_valid,
    input  logic [63:0] word_data,
    output logic        word_ready,
    output logic        word_done,
    output logic        uart_txd,
    output logic        busy,
    output logic [2:0]  fsm_state,
    output logic [3:0]  byte_cnt
);

    localparam logic [2:0] S_IDLE   = 3'b000;
    localparam logic [2:0] S_OPEN   = 3'b001;
    localparam logic [2:0] S_ACTIVE = 3'b010;
    localparam logic [2:0] S_SEND   = 3'b011;
    localparam logic [2:0] S_CLOSE  = 3'b100;

    localparam int              BAUD_W    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      BIT_LAST  = 4'(8 + STOP_BITS);

    logic [2:0]        state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [3:0]        bit_cnt;
    logic [3:0]        byte_cnt_q;
    logic [63:0]       shreg;
    logic              close_pend;
    logic              txd_q;
    logic              done_q;

    logic       sending;
    logic [7:0] cur_byte;
    logic [2:0] bit_idx;
    logic       line_bit;
    logic       bit_end;
    logic       byte_end;
    logic       group_end;

    always_comb begin
        sending  = (state == S_OPEN) || (state == S_SEND) || (state == S_CLOSE);
        cur_byte = shreg[63:56];
        case (state)
            S_OPEN:  cur_byte = 8'hAA;
            S_CLOSE: cur_byte = 8'h55;
            default: cur_byte = shreg[63:56];
        endcase
        bit_idx = 3'(bit_cnt - 4'd1);
        if (bit_cnt == 4'd0)
            line_bit = 1'b0;
        else if (bit_cnt <= 4'd8)
            line_bit = cur_byte[bit_idx];
        else
            line_bit = 1'b1;
        bit_end   = (baud_cnt == BAUD_LAST);
        byte_end  = bit_end && (bit_cnt == BIT_LAST);
        group_end = byte_end && (byte_cnt_q == 4'd7);
    end

    // The counters describe the bit the line will carry from the next edge,
    // so the line falls one edge after the state is entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            byte_cnt_q <= '0;
            shreg      <= '0;
            close_pend <= 1'b0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            txd_q  <= sending ? line_bit : 1'b1;
            case (state)
                S_IDLE: begin
                    if (open_req) begin
                        state      <= S_OPEN;
                        baud_cnt   <= '0;
                        bit_cnt    <= '0;
                        byte_cnt_q <= '0;
                    end
                end
                S_ACTIVE: begin
                    baud_cnt   <= '0;
                    bit_cnt    <= '0;
                    byte_cnt_q <= '0;
                    if (word_valid) begin
                        shreg <= word_data;
                        state <= S_SEND;
                        if (close_req)
                            close_pend <= 1'b1;
                    end else if (close_req || close_pend) begin
                        state <= S_CLOSE;
                    end
                end
                S_OPEN, S_SEND, S_CLOSE: begin
                    if (state == S_SEND && close_req)
                        close_pend <= 1'b1;
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (state == S_SEND)
                                shreg <= {shreg[55:0], 8'h00};
                            byte_cnt_q <= group_end ? 4'd0 : byte_cnt_q + 4'd1;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                    if (group_end) begin
                        case (state)
                            S_OPEN:  state <= S_ACTIVE;
                            S_SEND: begin
                                state  <= S_ACTIVE;
                                done_q <= 1'b1;
                            end
                            default: begin
                                state      <= S_IDLE;
                                close_pend <= 1'b0;
                            end
                        endcase
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign uart_txd   = txd_q;
    assign word_done  = done_q;
    assign word_ready = (state == S_ACTIVE);
    assign busy       = (state != S_IDLE) && (state != S_ACTIVE);
    assign fsm_state  = state;
    assign byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_output64_tx.sv
// Randomised bench for output64_tx: a line monitor decodes UART bytes and compares them
// against a byte-stream model built from the session/word sequence driven.
module tb_output64_tx;

    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB;

    localparam logic [2:0] S_IDLE   = 3'b000;
    localparam logic [2:0] S_OPEN   = 3'b001;
    localparam logic [2:0] S_ACTIVE = 3'b010;
    localparam logic [2:0] S_SEND   = 3'b011;
    localparam logic [2:0] S_CLOSE  = 3'b100;

    logic        clk;
    logic        reset;
    logic        open_req;
    logic        close_req;
    logic        word_valid;
    logic [63:0] word_data;
    logic        word_ready;
    logic        word_done;
    logic        uart_txd;
    logic        busy;
    logic [2:0]  fsm_state;
    logic [3:0]  byte_cnt;

    output64_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .open_req   (open_req),
        .close_req  (close_req),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .word_done  (word_done),
        .uart_txd   (uart_txd),
        .busy       (busy),
        .fsm_state  (fsm_state),
        .byte_cnt   (byte_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Line monitor: samples mid-bit, drops frames cut short by reset.
    logic [7:0] mon_q[$];
    int         mon_t[$];
    int         frame_err = 0;
    logic [7:0] mon_b;
    int         mon_t0;
    bit         mon_bad;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && uart_txd === 1'b0) begin
                mon_t0  = cyc;
                mon_bad = 0;
                mon_b   = 8'h00;
                for (int k = 0; k < 10; k++) begin
                    repeat ((k == 0) ? CPB / 2 : CPB) @(negedge clk);
                    if (reset) mon_bad = 1;
                    if (k == 0 && uart_txd !== 1'b0) mon_bad = 1;
                    if (k >= 1 && k <= 8) mon_b[k-1] = uart_txd;
                    if (k == 9 && uart_txd !== 1'b1 && !mon_bad) frame_err++;
                end
                if (!mon_bad) begin
                    mon_q.push_back(mon_b);
                    mon_t.push_back(mon_t0);
                end
            end
        end
    end

    // Reference byte stream.
    logic [7:0] exp_q[$];

    task automatic push_fill(input logic [7:0] b);
        for (int i = 0; i < 8; i++) exp_q.push_back(b);
    endtask

    task automatic push_word(input logic [63:0] w);
        for (int i = 7; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
    endtask

    task automatic cmp_bytes(input string tag);
        check({tag, "_count"}, 64'(mon_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 64'(mon_q[i]), 64'(exp_q[i]));
    endtask

    task automatic flush();
        mon_q.delete();
        mon_t.delete();
        exp_q.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (fsm_state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(fsm_state), 64'(s));
    endtask

    task automatic wait_done(input int budget, input string tag, output int at);
        int n = 0;
        while (word_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(word_done), 64'd1);
        at = cyc;
    endtask

    task automatic pulse_open(output int acc);
        @(posedge clk);
        #1 open_req = 1'b1;
        @(posedge clk);
        #1 acc = cyc;
        open_req = 1'b0;
    endtask

    task automatic open_session(input string tag);
        int acc;
        pulse_open(acc);
        push_fill(8'hAA);
        wait_state(S_ACTIVE, 12 * FRAME, {tag, "_open_to_active"});
    endtask

    // Hands a word over at the next ready cycle; returns the accepting edge's cycle number.
    task automatic send_word(input logic [63:0] w, input logic with_close, input string tag,
                             output int acc);
        int n = 0;
        while (word_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 64'(word_ready), 64'd1);
        word_valid = 1'b1;
        word_data  = w;
        close_req  = with_close;
        @(posedge clk);
        #1 acc = cyc;
        word_valid = 1'b0;
        close_req  = 1'b0;
        word_data  = {$urandom, $urandom};
        push_word(w);
    endtask

    task automatic single_word(input logic [63:0] w, input string tag);
        int acc, at;
        logic [63:0] rx;
        send_word(w, 1'b0, tag, acc);
        wait_done(12 * FRAME, {tag, "_done"}, at);
        check({tag, "_latency"}, 64'(at - acc), 64'(8 * FRAME));
        check({tag, "_ready_in_done"}, 64'(word_ready), 64'd1);
        @(negedge clk);
        check({tag, "_done_width"}, 64'(word_done), 64'd0);
        wait_cycles(5);
        cmp_bytes(tag);
        rx = '0;
        foreach (mon_q[i]) rx = {rx[55:0], mon_q[i]};
        check({tag, "_loopback"}, rx, w);
        flush();
    endtask

    initial begin
        int          acc, acc2, t1, t2, lows, n;
        logic [63:0] w1, w2, w;

        reset      = 1'b1;
        open_req   = 1'b0;
        close_req  = 1'b0;
        word_valid = 1'b0;
        word_data  = '0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_txd", 64'(uart_txd), 64'd1);
        check("rst_ready", 64'(word_ready), 64'd0);
        check("rst_done", 64'(word_done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_state", 64'(fsm_state), 64'(S_IDLE));
        check("rst_bytecnt", 64'(byte_cnt), 64'd0);

        // IDLE ignores words and close requests.
        word_valid = 1'b1;
        word_data  = {$urandom, $urandom};
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            close_req = (i == 10);
            @(negedge clk);
            if (uart_txd !== 1'b1) lows++;
        end
        close_req  = 1'b0;
        check("idle_ready_low", 64'(word_ready), 64'd0);
        word_valid = 1'b0;
        check("idle_quiet_line", 64'(lows), 64'd0);
        check("idle_state", 64'(fsm_state), 64'(S_IDLE));

        // Preamble.
        pulse_open(acc);
        push_fill(8'hAA);
        check("open_state", 64'(fsm_state), 64'(S_OPEN));
        check("open_busy", 64'(busy), 64'd1);
        while (cyc < acc + FRAME - 1) @(negedge clk);
        check("bytecnt_before_first", 64'(byte_cnt), 64'd0);
        @(negedge clk);
        check("bytecnt_after_first", 64'(byte_cnt), 64'd1);
        wait_state(S_ACTIVE, 12 * FRAME, "open_to_active");
        check("active_ready", 64'(word_ready), 64'd1);
        check("active_busy", 64'(busy), 64'd0);
        check("active_bytecnt", 64'(byte_cnt), 64'd0);
        wait_cycles(5);
        cmp_bytes("preamble");
        if (mon_t.size() > 0)
            check("first_fall_latency", 64'(mon_t[0] - acc), 64'd1);
        for (int i = 1; i < mon_t.size(); i++)
            check($sformatf("preamble_spacing%0d", i), 64'(mon_t[i] - mon_t[i-1]), 64'(FRAME));
        flush();

        single_word(64'h0123456789ABCDEF, "word_fixed");

        // Back-to-back with word_valid held high; the second word is taken in the done cycle
        // and the only extra line time between words is that one handshake cycle.
        w1 = 64'hAA00FF55AA00FF55;
        w2 = 64'hFFFFFFFFFFFFFFFF;
        n = 0;
        while (word_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        word_valid = 1'b1;
        word_data  = w1;
        @(posedge clk);
        #1 acc = cyc;
        word_data = w2;
        push_word(w1);
        push_word(w2);
        wait_done(12 * FRAME, "b2b_done1", t1);
        check("b2b_latency1", 64'(t1 - acc), 64'(8 * FRAME));
        check("b2b_ready_in_done", 64'(word_ready), 64'd1);
        @(posedge clk);
        #1 acc2 = cyc;
        word_valid = 1'b0;
        word_data  = {$urandom, $urandom};
        check("b2b_accept_in_done_cycle", 64'(acc2 - t1), 64'd1);
        @(negedge clk);
        check("b2b_second_send", 64'(fsm_state), 64'(S_SEND));
        check("b2b_done_width", 64'(word_done), 64'd0);
        wait_done(12 * FRAME, "b2b_done2", t2);
        check("b2b_latency2", 64'(t2 - acc2), 64'(8 * FRAME));
        wait_cycles(5);
        cmp_bytes("b2b");
        for (int i = 1; i < mon_t.size(); i++)
            check($sformatf("b2b_spacing%0d", i), 64'(mon_t[i] - mon_t[i-1]),
                  64'((i == 8) ? FRAME + 1 : FRAME));
        flush();

        for (int r = 0; r < 3; r++)
            single_word({$urandom, $urandom}, $sformatf("word_rand%0d", r));

        // Word and close together: word completes, then postamble; open_req in CLOSE ignored.
        w = {$urandom, $urandom};
        send_word(w, 1'b1, "close", acc);
        push_fill(8'h55);
        wait_done(12 * FRAME, "close_word_done", t1);
        check("close_word_latency", 64'(t1 - acc), 64'(8 * FRAME));
        wait_state(S_CLOSE, 10, "close_entered");
        check("close_busy", 64'(busy), 64'd1);
        open_req = 1'b1;
        @(posedge clk);
        #1 open_req = 1'b0;
        check("close_ignores_open", 64'(fsm_state), 64'(S_CLOSE));
        wait_state(S_IDLE, 12 * FRAME, "close_to_idle");
        wait_cycles(20);
        check("idle_after_close", 64'(fsm_state), 64'(S_IDLE));
        cmp_bytes("close");
        flush();

        // Reset in the middle of the third byte of a word.
        open_session("rs");
        flush();
        w = {$urandom, $urandom} & ~64'h0000_FF00_0000_0000;
        send_word(w, 1'b0, "rs_word", acc);
        n = 0;
        while (byte_cnt !== 4'd2 && n < 12 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("rs_reached_byte3", 64'(byte_cnt), 64'd2);
        wait_cycles(CPB + 2);
        check("rs_line_low_before", 64'(uart_txd), 64'd0);
        reset = 1'b1;
        #1;
        check("rs_txd", 64'(uart_txd), 64'd1);
        check("rs_ready", 64'(word_ready), 64'd0);
        check("rs_done", 64'(word_done), 64'd0);
        check("rs_busy", 64'(busy), 64'd0);
        check("rs_state", 64'(fsm_state), 64'(S_IDLE));
        check("rs_bytecnt", 64'(byte_cnt), 64'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        wait_cycles(60);
        flush();

        open_session("rs2");
        wait_cycles(5);
        check("rs2_stays_active", 64'(fsm_state), 64'(S_ACTIVE));
        w = {$urandom, $urandom};
        send_word(w, 1'b0, "rs2_word", acc);
        wait_done(12 * FRAME, "rs2_done", t1);
        check("rs2_latency", 64'(t1 - acc), 64'(8 * FRAME));
        @(negedge clk);
        close_req = 1'b1;
        @(posedge clk);
        #1 close_req = 1'b0;
        push_fill(8'h55);
        wait_state(S_IDLE, 12 * FRAME, "rs2_close_to_idle");
        wait_cycles(5);
        cmp_bytes("rs2");
        flush();

        check("frame_errors", 64'(frame_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, checks passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
